// File: rtl/hevc_interp_pkg.sv
// -----------------------------------------------------------------------------
// hevc_interp_pkg
// Shared definitions for the interpolation-filter pixel interface.
//   - state_t : window feeder FSM states (PAD exists only when the
//               HEVC_EDGE_PAD_EN macro is defined)
//   - TAPS    : samples per filter window
//   - PIX_W   : bits per reference pixel
//   - WIN_W   : flattened window width, from win_bits()
// -----------------------------------------------------------------------------
package hevc_interp_pkg;

  localparam int TAPS  = 8;
  localparam int PIX_W = 8;

  function automatic int win_bits();
    return TAPS * PIX_W;
  endfunction

  localparam int WIN_W = win_bits();

`ifdef HEVC_EDGE_PAD_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    PAD    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/hevc_window_shreg.sv
// -----------------------------------------------------------------------------
// hevc_window_shreg
// TAPS-deep byte shift register holding the current filter window. New
// samples enter at the top byte; the byte at [7:0] (oldest) falls off.
// Ports:
//   clock     rising-edge clock
//   reset_L   asynchronous active-low reset, clears the window
//   shift_en  shift din into the window this cycle
//   hold      output-hold: freezes the window even if shift_en is high
//   din       sample to shift in
//   window    flattened window, [7:0] oldest, top byte newest
// -----------------------------------------------------------------------------
module hevc_window_shreg
  import hevc_interp_pkg::*;
(
  input  logic             clock,
  input  logic             reset_L,
  input  logic             shift_en,
  input  logic             hold,
  input  logic [PIX_W-1:0] din,
  output logic [WIN_W-1:0] window
);

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      window <= '0;
    end else if (shift_en && !hold) begin
      window <= {din, window[WIN_W-1:PIX_W]};
    end
  end

endmodule

// File: rtl/hevc_window_feeder.sv
// -----------------------------------------------------------------------------
// hevc_window_feeder
// Converts a serial stream of reference pixels into TAPS-sample sliding
// windows for the FIR filter bank, one window per integer output position,
// WIDTH windows per row, valid/ready on both sides.
//
// Optional feature: define HEVC_EDGE_PAD_EN to have the block replicate the
// row edges itself (source then supplies WIDTH pixels instead of WIDTH+7).
//
// Ports:
//   clock      rising-edge clock
//   reset_L    asynchronous active-low reset
//   start      row-start command, honoured only in IDLE
//   frac_cfg   fractional position, latched on an accepted start
//   pix_in     reference pixel
//   pix_valid  pix_in valid
//   pix_ready  pixel accepted this cycle when pix_valid is also high
//   window     flattened window, [7:0] oldest sample, [63:56] newest
//   so         fractional tag travelling with the window
//   win_valid  window / so / win_last valid
//   win_ready  downstream accepts the window
//   win_last   final window of the row
//   busy       high in every state except IDLE
// -----------------------------------------------------------------------------
module hevc_window_feeder
  import hevc_interp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 8)
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             start,
  input  logic [1:0]       frac_cfg,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [WIN_W-1:0] window,
  output logic [1:0]       so,
  output logic             win_valid,
  input  logic             win_ready,
  output logic             win_last,
  output logic             busy
);

  // Shifts needed per row, the shift that completes the first full window,
  // and the index of the final window.
  localparam logic [CNT_W-1:0] SH_TOT  = CNT_W'(WIDTH + TAPS - 1);
  localparam logic [CNT_W-1:0] SH_PRE  = CNT_W'(TAPS - 1);
  localparam logic [CNT_W-1:0] WIN_END = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] sh_cnt;
  logic [CNT_W-1:0] win_cnt;
  logic             out_ok;
  logic             pix_xfer;
  logic             win_xfer;
  logic             row_done;
  logic             full_next;
  logic             shift;
  logic [PIX_W-1:0] shift_data;

  // A new window may be produced only if the output slot is free or is
  // being handed off in this same cycle.
  assign out_ok    = !win_valid || win_ready;
  assign win_xfer  = win_valid && win_ready;
  assign row_done  = win_xfer && (win_cnt == WIN_END);
  assign win_last  = win_valid && (win_cnt == WIN_END);
  assign busy      = (state != IDLE);
  assign pix_xfer  = pix_valid && pix_ready;
  // This shift fills (or keeps) the window complete.
  assign full_next = (sh_cnt >= SH_PRE);

`ifdef HEVC_EDGE_PAD_EN
  localparam logic [CNT_W-1:0] PX_END = CNT_W'(WIDTH);

  logic [CNT_W-1:0] px_cnt;
  logic [2:0]       rep_cnt;
  logic [2:0]       rep_load;
  logic [PIX_W-1:0] rep_pix;
  logic             int_shift;

  assign pix_ready  = ((state == FILL) || (state == STREAM)) && out_ok && (px_cnt != PX_END);
  assign int_shift  = (state == PAD) && out_ok;
  assign shift      = pix_xfer || int_shift;
  assign shift_data = pix_xfer ? pix_in : rep_pix;

  // Internal copies owed after an accepted pixel: 3 after the first (left
  // edge), 4 after the last (right edge); both when WIDTH is 1.
  always_comb begin
    rep_load = 3'd0;
    if (px_cnt == '0) begin
      rep_load = 3'd3;
    end
    if (px_cnt == WIN_END) begin
      rep_load = rep_load + 3'd4;
    end
  end
`else
  assign pix_ready  = (state == FILL) ||
                      ((state == STREAM) && out_ok && (sh_cnt != SH_TOT));
  assign shift      = pix_xfer;
  assign shift_data = pix_in;
`endif

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      so        <= '0;
      win_valid <= 1'b0;
      sh_cnt    <= '0;
      win_cnt   <= '0;
`ifdef HEVC_EDGE_PAD_EN
      px_cnt    <= '0;
      rep_cnt   <= '0;
      rep_pix   <= '0;
`endif
    end else begin
      if ((state == IDLE) && start) begin
        so    <= frac_cfg;
        state <= FILL;
      end

      if (shift && (sh_cnt != SH_TOT)) begin
        sh_cnt <= sh_cnt + 1'b1;
      end

      if (shift && full_next) begin
        win_valid <= 1'b1;
      end else if (win_xfer) begin
        win_valid <= 1'b0;
      end

      if (win_xfer && (win_cnt != WIN_END)) begin
        win_cnt <= win_cnt + 1'b1;
      end

`ifdef HEVC_EDGE_PAD_EN
      if (pix_xfer) begin
        rep_pix <= pix_in;
        if (px_cnt != PX_END) begin
          px_cnt <= px_cnt + 1'b1;
        end
        if (rep_load != 3'd0) begin
          rep_cnt <= rep_load;
          state   <= PAD;
        end else if (full_next) begin
          state <= STREAM;
        end
      end

      if (int_shift) begin
        rep_cnt <= rep_cnt - 3'd1;
        if (rep_cnt == 3'd1) begin
          state <= full_next ? STREAM : FILL;
        end
      end
`else
      if ((state == FILL) && shift && full_next) begin
        state <= STREAM;
      end
`endif

      // Final window handed off: row complete, everything back to idle.
      if (row_done) begin
        state     <= IDLE;
        win_valid <= 1'b0;
        sh_cnt    <= '0;
        win_cnt   <= '0;
`ifdef HEVC_EDGE_PAD_EN
        px_cnt    <= '0;
        rep_cnt   <= '0;
`endif
      end
    end
  end

  hevc_window_shreg u_shreg (
    .clock    (clock),
    .reset_L  (reset_L),
    .shift_en (shift),
    .hold     (!out_ok),
    .din      (shift_data),
    .window   (window)
  );

endmodule

// File: tb/tb_hevc_window_feeder.sv
// -----------------------------------------------------------------------------
// tb_hevc_window_feeder
// Directed bench for hevc_window_feeder with WIDTH=4. Builds with or without
// HEVC_EDGE_PAD_EN; the directed rows differ between the two builds.
// -----------------------------------------------------------------------------
module tb_hevc_window_feeder;

  localparam int WIDTH = 4;

  logic        clock = 1'b0;
  logic        reset_L = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  frac_cfg = 2'b00;
  logic [7:0]  pix_in = 8'h00;
  logic        pix_valid = 1'b0;
  logic        win_ready = 1'b0;
  logic        pix_ready;
  logic [63:0] window;
  logic [1:0]  so;
  logic        win_valid;
  logic        win_last;
  logic        busy;

  int n_pass = 0;
  int n_chk  = 0;

  logic [7:0]  src [16];
  logic [63:0] exp_win [4];

  hevc_window_feeder #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .start     (start),
    .frac_cfg  (frac_cfg),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .window    (window),
    .so        (so),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_last  (win_last),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 with the FSM out of IDLE.
  task automatic start_row(input logic [1:0] f);
    frac_cfg = f;
    start    = 1'b1;
    @(posedge clock); #1;
    start    = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  // Streams src[] (n_avail pixels offered) and checks every window against
  // exp_win[]. tog: pixel offered every other cycle. stall_idx/stall_len:
  // hold win_ready low while window stall_idx is presented.
  task automatic run_row(input int n_avail, input int n_exp_pix, input logic [1:0] exp_so,
                         input bit tog, input int stall_idx, input int stall_len,
                         input bit mid_start);
    int pidx = 0;
    int widx = 0;
    int cyc  = 0;
    int first_cyc = 0;
    int last_cyc  = 0;
    int stall_left = stall_len;
    bit done = 1'b0;
    while (!done && cyc < 300) begin
      pix_valid = (pidx < n_avail) && (!tog || (cyc % 2 == 0));
      pix_in    = (pidx < 16) ? src[pidx] : 8'h00;
      win_ready = 1'b1;
      if (win_valid && widx == stall_idx && stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
      end
      if (mid_start && cyc == 3) begin
        start    = 1'b1;
        frac_cfg = 2'b01;
      end else begin
        start = 1'b0;
      end
      #1;
      if (!win_ready) begin
        check("stall_window", window, exp_win[widx]);
        check("stall_pix_ready", 64'(pix_ready), 64'(0));
      end
      if (tog && widx > 0 && (cyc % 2 == 0)) begin
        check("gap_win_valid", 64'(win_valid), 64'(0));
      end
      if (win_valid && win_ready) begin
        check("window", window, exp_win[widx]);
        check("so", 64'(so), 64'(exp_so));
        check("win_last", 64'(win_last), 64'(widx == WIDTH - 1));
        if (widx == 0) first_cyc = cyc;
        last_cyc = cyc;
        widx++;
        if (widx == WIDTH) done = 1'b1;
      end
      if (pix_valid && pix_ready) pidx++;
      @(posedge clock); #1;
      cyc++;
    end
    start     = 1'b0;
    pix_valid = 1'b0;
    check("windows_seen", 64'(widx), 64'(WIDTH));
    check("pixels_consumed", 64'(pidx), 64'(n_exp_pix));
    check("busy_after_row", 64'(busy), 64'(0));
    check("win_valid_after_row", 64'(win_valid), 64'(0));
    if (!tog && stall_len == 0) begin
      check("throughput", 64'(last_cyc - first_cyc), 64'(WIDTH - 1));
    end
  endtask

  initial begin
    // Reset state
    @(posedge clock); @(posedge clock); #1;
    check("rst_window", window, 64'h0);
    check("rst_so", 64'(so), 64'(0));
    check("rst_win_valid", 64'(win_valid), 64'(0));
    check("rst_win_last", 64'(win_last), 64'(0));
    check("rst_pix_ready", 64'(pix_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    reset_L = 1'b1;
    @(posedge clock); #1;

`ifdef HEVC_EDGE_PAD_EN
    src[0] = 8'h0A; src[1] = 8'h14; src[2] = 8'h1E; src[3] = 8'h28;
    src[4] = 8'h33; src[5] = 8'h44;
    for (int i = 6; i < 16; i++) src[i] = 8'h00;
    exp_win[0] = 64'h28281E140A0A0A0A;
    exp_win[1] = 64'h2828281E140A0A0A;
    exp_win[2] = 64'h282828281E140A0A;
    exp_win[3] = 64'h28282828281E140A;

    // Edge-padded row, free-flowing output
    start_row(2'b11);
    run_row(6, 4, 2'b11, 1'b0, -1, 0, 1'b0);

    // Edge-padded row with a stall on the 2nd window
    @(posedge clock); #1;
    start_row(2'b01);
    run_row(6, 4, 2'b01, 1'b0, 1, 5, 1'b0);
`else
    for (int i = 0; i < 16; i++) src[i] = 8'(i);
    exp_win[0] = 64'h0706050403020100;
    exp_win[1] = 64'h0807060504030201;
    exp_win[2] = 64'h0908070605040302;
    exp_win[3] = 64'h0A09080706050403;

    // Basic row: 0x00..0x0C offered, only 11 may be consumed
    start_row(2'b00);
    run_row(13, 11, 2'b00, 1'b0, -1, 0, 1'b0);

    // so latched on start; mid-row frac change and start ignored
    @(posedge clock); #1;
    start_row(2'b10);
    run_row(13, 11, 2'b10, 1'b0, -1, 0, 1'b1);
    check("so_held_after_row", 64'(so), 64'(2'b10));

    // Output stall of 5 cycles on the 2nd window
    @(posedge clock); #1;
    start_row(2'b00);
    run_row(13, 11, 2'b00, 1'b0, 1, 5, 1'b0);

    // Pixel source valid every other cycle
    @(posedge clock); #1;
    start_row(2'b00);
    run_row(13, 11, 2'b00, 1'b1, -1, 0, 1'b0);

    // Asynchronous reset after 6 pixels of a row
    @(posedge clock); #1;
    start_row(2'b11);
    for (int i = 0; i < 6; i++) begin
      pix_valid = 1'b1;
      pix_in    = 8'h50 + 8'(i);
      @(posedge clock); #1;
    end
    pix_valid = 1'b0;
    check("pre_reset_window", window, 64'h5554535251500A09);
    check("pre_reset_so", 64'(so), 64'(2'b11));
    #2;
    reset_L = 1'b0;
    #1;
    check("async_rst_window", window, 64'h0);
    check("async_rst_so", 64'(so), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_pix_ready", 64'(pix_ready), 64'(0));
    check("async_rst_win_valid", 64'(win_valid), 64'(0));
    @(posedge clock); #1;
    reset_L = 1'b1;
    @(posedge clock); #1;
    start_row(2'b01);
    run_row(13, 11, 2'b01, 1'b0, -1, 0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
